// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue: buffers up to DEPTH {pc, inst} pairs, squashes on flush.
// Optional same-cycle fetch-to-decode forwarding when empty is enabled by defining FDQ_BYPASS_EN.
module fetch_decode_queue #(
    parameter int          DEPTH    = 4,
    parameter int          AW       = 2,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_valid,
    input  logic [31:0]   if_pc,
    input  logic [31:0]   if_inst,
    output logic          if_ready,
    input  logic          flush,
    output logic          id_valid,
    output logic [31:0]   id_pc,
    output logic [31:0]   id_inst,
    input  logic          id_ready,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [31:0]   mem_pc_q   [DEPTH];
    logic [31:0]   mem_inst_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic empty, full, byp;
    logic push, pop, mem_wr, mem_rd;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

`ifdef FDQ_BYPASS_EN
    assign byp = empty & if_valid & ~flush;
`else
    assign byp = 1'b0;
`endif

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // the producer holds its offer stable until it is taken, and flush forces both readies/valids low.
    assign if_ready = ~full & ~flush;
    assign id_valid = (~empty & ~flush) | byp;

    assign push = if_valid & if_ready;
    assign pop  = id_valid & id_ready;

    // A forwarded entry that decode takes at once never touches the array.
    assign mem_wr = push & ~(byp & id_ready);
    assign mem_rd = pop & ~byp;

    always_comb begin
        id_pc   = 32'h0;
        id_inst = NOP_WORD;
        if (byp) begin
            id_pc   = if_pc;
            id_inst = if_inst;
        end else if (id_valid) begin
            id_pc   = mem_pc_q[rd_ptr_q];
            id_inst = mem_inst_q[rd_ptr_q];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (mem_wr) wr_ptr_d = wr_ptr_q + 1'b1;
            if (mem_rd) rd_ptr_d = rd_ptr_q + 1'b1;
            if (mem_wr && !mem_rd)      count_d = count_q + 1'b1;
            else if (mem_rd && !mem_wr) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is intentionally left unreset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem_pc_q[wr_ptr_q]   <= if_pc;
            mem_inst_q[wr_ptr_q] <= if_inst;
        end
    end

    assign count = count_q;

endmodule
